bcd_convert_scheduler: RTL and testbench

//   Shares one shift-and-add-3 (double-dabble) binary-to-BCD engine among NUM_CH requesters.

---
 rtl/bcd_convert_scheduler.sv | 129 ++++++++++++
 tb/tb_bcd_convert_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_convert_scheduler.sv
// Purpose : one shared double-dabble binary-to-BCD engine, round-robin arbitrated among NUM_CH requesters.
// Latency : result valid exactly WIDTH cycles after the accept edge; one conversion in flight at a time.
// Backpressure: req_ready stays low while converting or holding a result; result held stable until out_ready.
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   req_valid/req_value   per-channel request and binary value (ch i at [i*WIDTH +: WIDTH])
//   req_ready             one-hot combinational grant, only in IDLE
//   out_valid/out_ready   result handshake; out_ch = owning channel, out_bcd = digits (MSD on top)
//   busy                  high whenever a conversion or result is outstanding
module bcd_convert_scheduler #(
  parameter  int NUM_CH = 4,
  parameter  int WIDTH  = 8,
  parameter  int DIGITS = 3,
  localparam int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       req_valid,
  input  logic [NUM_CH*WIDTH-1:0] req_value,
  output logic [NUM_CH-1:0]       req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CHW-1:0]          out_ch,
  output logic [4*DIGITS-1:0]     out_bcd,
  output logic                    busy
);

  localparam int SRW = WIDTH + 4*DIGITS;
  localparam int ITW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CHW-1:0]   r_last;
  logic [SRW-1:0]   r_sr;
  logic [ITW-1:0]   r_iter;

  logic             w_gnt_vld;
  logic [CHW-1:0]   w_gnt;
  logic [WIDTH-1:0] w_gnt_val;
  int               w_best;
  logic             w_last_iter;
  logic [SRW-1:0]   w_sr_adj;
  logic [SRW-1:0]   w_sr_step;

  // Round-robin pick: cyclic distance from the last grant; distance 0 is the
  // channel right after r_last, so the previous winner has the lowest priority.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_gnt_val = '0;
    w_best    = NUM_CH;
    for (int i = 0; i < NUM_CH; i++) begin
      if (req_valid[i] && (((i + NUM_CH - 1 - int'(r_last)) % NUM_CH) < w_best)) begin
        w_best    = (i + NUM_CH - 1 - int'(r_last)) % NUM_CH;
        w_gnt_vld = 1'b1;
        w_gnt     = CHW'(i);
        w_gnt_val = req_value[i*WIDTH +: WIDTH];
      end
    end
  end

  // One double-dabble iteration: nibbles >= 5 get +3 independently, then shift.
  always_comb begin
    w_sr_adj = r_sr;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_sr[WIDTH + 4*d +: 4] >= 4'd5)
        w_sr_adj[WIDTH + 4*d +: 4] = r_sr[WIDTH + 4*d +: 4] + 4'd3;
    end
    w_sr_step = w_sr_adj << 1;
  end

  assign w_last_iter = (r_iter == ITW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_gnt_vld) begin
          req_ready[w_gnt] = 1'b1;
          w_state_nxt      = S_CONV;
        end
      end
      S_CONV: if (w_last_iter) w_state_nxt = S_DONE;
      S_DONE: if (out_ready)   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last    <= CHW'(NUM_CH - 1);
      r_sr      <= '0;
      r_iter    <= '0;
      out_valid <= 1'b0;
      out_bcd   <= '0;
      out_ch    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_gnt_vld) begin
          r_sr   <= {{(4*DIGITS){1'b0}}, w_gnt_val};
          r_iter <= '0;
          r_last <= w_gnt;
        end
        S_CONV: begin
          r_sr   <= w_sr_step;
          r_iter <= r_iter + 1'b1;
          if (w_last_iter) begin
            out_valid <= 1'b1;
            out_bcd   <= w_sr_step[SRW-1 -: 4*DIGITS];
            out_ch    <= r_last;
          end
        end
        S_DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_convert_scheduler.sv
module tb_bcd_convert_scheduler;
  localparam int NC = 4;
  localparam int W  = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NC-1:0]  req_valid = '0;
  logic [NC*W-1:0] req_value = '0;
  logic [NC-1:0]  req_ready;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [1:0]     out_ch;
  logic [11:0]    out_bcd;
  logic           busy;

  bcd_convert_scheduler #(.NUM_CH(NC), .WIDTH(W), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_value(req_value),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_bcd(out_bcd), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int          grant_q[$];
  int          res_ch[$];
  logic [11:0] res_bcd[$];

  // Reference model: 0 idle, 1 converting (m_cnt edges left), 2 holding result
  int            m_st = 0;
  int            m_last = NC - 1;
  int            m_cnt = 0;
  int            m_ch = 0;
  int            m_val = 0;
  bit            m_en = 1'b0;
  bit            g_acc = 1'b0;
  int            g_acc_ch = 0;
  bit            stepped_acc = 1'b0;
  logic [NC-1:0] sticky = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int rr_pick(input logic [NC-1:0] v, input int last);
    for (int k = 1; k <= NC; k++)
      if (v[(last + k) % NC]) return (last + k) % NC;
    return -1;
  endfunction

  always @(negedge clk) begin
    int g;
    logic [NC-1:0] rr_exp;
    g = rr_pick(req_valid, m_last);
    rr_exp = '0;
    if (g >= 0) rr_exp[g] = 1'b1;
    g_acc = 1'b0;
    if (m_en) begin
      case (m_st)
        0: begin
          chk("idle_busy", 32'(busy), 32'd0);
          chk("idle_out_valid", 32'(out_valid), 32'd0);
          chk("idle_req_ready", 32'(req_ready), 32'(rr_exp));
        end
        1: begin
          chk("conv_busy", 32'(busy), 32'd1);
          chk("conv_out_valid", 32'(out_valid), 32'd0);
          chk("conv_req_ready", 32'(req_ready), 32'd0);
        end
        default: begin
          chk("done_busy", 32'(busy), 32'd1);
          chk("done_out_valid", 32'(out_valid), 32'd1);
          chk("done_req_ready", 32'(req_ready), 32'd0);
          chk("done_out_bcd", 32'(out_bcd), 32'(to_bcd(m_val)));
          chk("done_out_ch", 32'(out_ch), 32'(m_ch));
        end
      endcase
    end
    if (rst) begin
      m_st = 0; m_last = NC - 1; m_en = 1'b1;
    end else if (m_en) begin
      case (m_st)
        0: if (g >= 0) begin
          g_acc = 1'b1; g_acc_ch = g; grant_q.push_back(g);
          m_last = g; m_ch = g; m_val = int'(req_value[g*W +: W]);
          m_cnt = W; m_st = 1;
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) m_st = 2;
        end
        default: if (out_ready) begin
          res_ch.push_back(int'(out_ch));
          res_bcd.push_back(out_bcd);
          m_st = 0;
        end
      endcase
    end
  end

  // Advance one cycle; one-shot requesters drop valid after their accept edge.
  task automatic step();
    @(posedge clk);
    #1;
    stepped_acc = g_acc;
    if (g_acc && !sticky[g_acc_ch]) req_valid[g_acc_ch] = 1'b0;
  endtask

  task automatic wait_acc(input string nm);
    int k = 0;
    do begin step(); k++; end while (!stepped_acc && k < 50);
    if (!stepped_acc) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_res(input int n, input int budget, input string nm);
    int k = 0;
    while (res_ch.size() < n && k < budget) begin step(); k++; end
    chk(nm, 32'(res_ch.size()), 32'(n));
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || (|req_valid)) && k < 300) begin step(); k++; end
    chk("drain_idle", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  initial begin
    int base, gb, v, ch, k, distinct, dv;
    logic [11:0] e2[4];
    int e4[4];
    int seen[256];
    logic [11:0] b;

    // Reset state
    do_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_bcd", 32'(out_bcd), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);

    // 1: ch0=255, latency exactly 8 cycles after accept
    out_ready = 1'b1;
    req_value[7:0] = 8'd255;
    req_valid = 4'b0001;
    #1;
    chk("t1_req_ready", 32'(req_ready), 32'h1);
    wait_acc("t1");
    repeat (7) step();
    chk("t1_lat_early", 32'(out_valid), 32'd0);
    step();
    chk("t1_lat_at8", 32'(out_valid), 32'd1);
    chk("t1_bcd", 32'(out_bcd), 32'h255);
    chk("t1_ch", 32'(out_ch), 32'd0);
    wait_res(1, 20, "t1_count");

    // 2: all four at once from reset pointer -> ch0..ch3
    do_reset();
    base = res_ch.size();
    gb = grant_q.size();
    req_value = {8'd200, 8'd100, 8'd99, 8'd0};
    req_valid = 4'hF;
    wait_res(base + 4, 100, "t2_count");
    e2[0] = 12'h000; e2[1] = 12'h099; e2[2] = 12'h100; e2[3] = 12'h200;
    for (int i = 0; i < 4; i++) begin
      chk("t2_ch", 32'(res_ch[base + i]), 32'(i));
      chk("t2_bcd", 32'(res_bcd[base + i]), 32'(e2[i]));
    end
    chk("t2_grants", 32'(grant_q.size() - gb), 32'd4);

    // 3: backpressure hold with a competing request
    wait_idle();
    base = res_ch.size();
    out_ready = 1'b0;
    req_value[23:16] = 8'd137;
    req_valid = 4'b0100;
    k = 0;
    while (!out_valid && k < 30) begin step(); k++; end
    chk("t3_out_valid", 32'(out_valid), 32'd1);
    req_value[7:0] = 8'd42;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_bcd", 32'(out_bcd), 32'h137);
      chk("t3_hold_ch", 32'(out_ch), 32'd2);
      chk("t3_hold_rdy", 32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("t3_idle_next", 32'(busy), 32'd0);
    wait_res(base + 2, 40, "t3_count");
    chk("t3_next_ch", 32'(res_ch[base + 1]), 32'd0);
    chk("t3_next_bcd", 32'(res_bcd[base + 1]), 32'h042);

    // 4: ch1 and ch3 continuously valid -> 1,3,1,3
    wait_idle();
    req_value[15:8] = 8'd7;
    req_value[31:24] = 8'd250;
    sticky = 4'b1010;
    req_valid = 4'b1010;
    gb = grant_q.size();
    k = 0;
    while (grant_q.size() < gb + 4 && k < 200) begin step(); k++; end
    sticky = '0;
    req_valid = '0;
    chk("t4_grants", 32'(grant_q.size()), 32'(gb + 4));
    e4[0] = 1; e4[1] = 3; e4[2] = 1; e4[3] = 3;
    for (int i = 0; i < 4; i++)
      if (gb + i < grant_q.size()) chk("t4_order", 32'(grant_q[gb + i]), 32'(e4[i]));
    wait_idle();

    // 5: reset during CONV iteration 4, then pointer back to ch0
    base = res_ch.size();
    req_value[15:8] = 8'd200;
    req_valid = 4'b0010;
    wait_acc("t5a");
    repeat (4) step();
    rst = 1'b1;
    step();
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    chk("t5_no_result", 32'(res_ch.size()), 32'(base));
    req_value[7:0] = 8'd5;
    req_value[31:24] = 8'd250;
    req_valid = 4'b1001;
    wait_acc("t5b");
    chk("t5_first_grant", 32'(grant_q[grant_q.size() - 1]), 32'd0);
    wait_res(base + 2, 60, "t5_count");
    chk("t5_r0_ch", 32'(res_ch[base]), 32'd0);
    chk("t5_r0_bcd", 32'(res_bcd[base]), 32'h005);
    chk("t5_r1_ch", 32'(res_ch[base + 1]), 32'd3);
    chk("t5_r1_bcd", 32'(res_bcd[base + 1]), 32'h250);

    // 6: every value 0..255 on random channels with random stalls
    wait_idle();
    base = res_ch.size();
    v = 0;
    k = 0;
    while (v < 256 && k < 20000) begin
      ch = int'($urandom_range(0, NC - 1));
      if (!req_valid[ch]) begin
        req_value[ch*W +: W] = 8'(v);
        req_valid[ch] = 1'b1;
        v++;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      k++;
    end
    out_ready = 1'b1;
    wait_res(base + 256, 5000, "t6_count");
    for (int i = 0; i < 256; i++) seen[i] = 0;
    for (int i = base; i < res_bcd.size(); i++) begin
      b = res_bcd[i];
      dv = int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
      if (dv < 256) seen[dv]++;
    end
    distinct = 0;
    for (int i = 0; i < 256; i++) if (seen[i] == 1) distinct++;
    chk("t6_unique", 32'(distinct), 32'd256);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
